// File: rtl/setmem_sdiv_32s_32s_32_seq.sv
// Sequential radix-2 restoring signed divider with a start/done handshake and ce stall.
// Optional macro SETMEM_SDIV_EARLY_EXIT_EN skips the iteration loop for zero divisors and |din0| < |din1|.
module setmem_sdiv_32s_32s_32_seq #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 34,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [dout_WIDTH-1:0] remd
);

  localparam int W  = din0_WIDTH;
  localparam int CW = $clog2(W) + 1;

  // Handshake: start is taken only when state is IDLE and ce=1; done is a
  // one-ce-cycle pulse with dout/remd valid from that cycle until the next FIX.
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    quo;      // dividend bits shift out MSB-first, quotient bits shift in
  logic [W-1:0]    rem;
  logic [W-1:0]    dvsr;
  logic            sign_q, sign_r;
  logic [CW-1:0]   cnt;

  logic signed [W-1:0] a_ext, b_ext;
  logic [W-1:0]    a_mag, b_mag;
  logic            sign0, sign1;
  logic [W:0]      rem_sh;
  logic            ge;
  logic [W-1:0]    diff;
  logic            early;

  // A W-bit two's-complement negate read as unsigned is exact for the most-negative value.
  assign a_ext = $signed(din0);
  assign b_ext = W'($signed(din1));
  assign sign0 = a_ext[W-1];
  assign sign1 = b_ext[W-1];
  assign a_mag = sign0 ? (W'(0) - a_ext) : a_ext;
  assign b_mag = sign1 ? (W'(0) - b_ext) : b_ext;

  assign rem_sh = {rem, quo[W-1]};
  assign ge     = rem_sh >= {1'b0, dvsr};
  assign diff   = rem_sh[W-1:0] - dvsr;

`ifdef SETMEM_SDIV_EARLY_EXIT_EN
  assign early = (b_mag == '0) || (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = early ? FIX : RUN;
      RUN:  if (cnt == CW'(W - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      dout   <= '0;
      remd   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (ce) begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvsr   <= b_mag;
            sign_q <= sign0 ^ sign1;
            sign_r <= sign0;
            cnt    <= '0;
            if (early) begin
              // Matches what the full loop would produce for these operands.
              quo <= (b_mag == '0) ? '1 : '0;
              rem <= a_mag;
            end else begin
              quo <= a_mag;
              rem <= '0;
            end
          end
        end
        RUN: begin
          rem <= ge ? diff : rem_sh[W-1:0];
          quo <= {quo[W-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          dout <= sign_q ? (W'(0) - quo) : quo;
          remd <= sign_r ? (W'(0) - rem) : rem;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_setmem_sdiv_32s_32s_32_seq.sv
// Directed self-checking bench for setmem_sdiv_32s_32s_32_seq (honours SETMEM_SDIV_EARLY_EXIT_EN).
module tb_setmem_sdiv_32s_32s_32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [31:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic        busy, done;
  logic [31:0] dout, remd;

  int checks = 0;
  int errors = 0;

  localparam int FULL = 34;
`ifdef SETMEM_SDIV_EARLY_EXIT_EN
  localparam int SHORT = 2;
`else
  localparam int SHORT = 34;
`endif

  always #5 clk = ~clk;

  setmem_sdiv_32s_32s_32_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .din0(din0), .din1(din1),
    .busy(busy), .done(done), .dout(dout), .remd(remd)
  );

  // Called 1 time unit after a rising edge; start is sampled at the next edge (cycle 0).
  task automatic apply_start(input logic [31:0] a, input logic [31:0] b);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from cycle 1 until done; ce is dropped for 10 cycles from ce_off (0 = never).
  task automatic wait_done(input int ce_off, output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      ce = !(ce_off != 0 && cyc >= ce_off && cyc < ce_off + 10);
      @(posedge clk); #1;
      cyc++;
    end
    ce = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
    checks++; if (remd !== 32'h0) begin errors++; $display("FAIL reset_remd got %h exp 0", remd); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc; bit bok;
    apply_start(32'd100, 32'd7);
    wait_done(0, cyc, bok);
    checks++; if (cyc != FULL) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cyc, FULL); end
    checks++; if (!bok) begin errors++; $display("FAIL basic_busy got low exp high in cycles 1..33"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %0b exp 0", busy); end
    checks++; if (dout !== 32'd14) begin errors++; $display("FAIL basic_dout got %h exp %h", dout, 32'd14); end
    checks++; if (remd !== 32'd2) begin errors++; $display("FAIL basic_remd got %h exp %h", remd, 32'd2); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_v [3] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C};
    logic [31:0] b_v [3] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] q_v [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
    logic [31:0] r_v [3] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE};
    int cyc; bit bok;
    apply_start(a_v[0], b_v[0]);
    for (int i = 0; i < 3; i++) begin
      wait_done(0, cyc, bok);
      checks++; if (cyc != FULL) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, cyc, FULL); end
      checks++; if (dout !== q_v[i]) begin errors++; $display("FAIL b2b_dout[%0d] got %h exp %h", i, dout, q_v[i]); end
      checks++; if (remd !== r_v[i]) begin errors++; $display("FAIL b2b_remd[%0d] got %h exp %h", i, remd, r_v[i]); end
      if (i < 2) apply_start(a_v[i+1], b_v[i+1]);
    end
  endtask

  task automatic test_corner;
    logic [31:0] a_v [3] = '{32'h80000000, 32'd5, 32'hFFFFFFFB};
    logic [31:0] b_v [3] = '{32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] q_v [3] = '{32'h80000000, 32'hFFFFFFFF, 32'd1};
    logic [31:0] r_v [3] = '{32'd0, 32'd5, 32'hFFFFFFFB};
    int lat_v [3] = '{FULL, SHORT, SHORT};
    int cyc; bit bok;
    for (int i = 0; i < 3; i++) begin
      apply_start(a_v[i], b_v[i]);
      wait_done(0, cyc, bok);
      checks++; if (cyc != lat_v[i]) begin errors++; $display("FAIL corner_latency[%0d] got %0d exp %0d", i, cyc, lat_v[i]); end
      checks++; if (dout !== q_v[i]) begin errors++; $display("FAIL corner_dout[%0d] got %h exp %h", i, dout, q_v[i]); end
      checks++; if (remd !== r_v[i]) begin errors++; $display("FAIL corner_remd[%0d] got %h exp %h", i, remd, r_v[i]); end
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    apply_start(32'd100, 32'd7);
    din0 = 32'd9; din1 = 32'd2;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      start = (cyc >= 5 && cyc <= 12);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc != FULL) begin errors++; $display("FAIL busy_start_latency got %0d exp %0d", cyc, FULL); end
    checks++; if (dout !== 32'd14) begin errors++; $display("FAIL busy_start_dout got %h exp %h", dout, 32'd14); end
    checks++; if (remd !== 32'd2) begin errors++; $display("FAIL busy_start_remd got %h exp %h", remd, 32'd2); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued got busy %0b exp 0", busy); end
  endtask

  task automatic test_ce_stall;
    int cyc; bit bok;
    apply_start(32'd1000, 32'd3);
    wait_done(10, cyc, bok);
    checks++; if (cyc != FULL + 10) begin errors++; $display("FAIL ce_latency got %0d exp %0d", cyc, FULL + 10); end
    checks++; if (!bok) begin errors++; $display("FAIL ce_busy got low exp high while running"); end
    checks++; if (dout !== 32'd333) begin errors++; $display("FAIL ce_dout got %h exp %h", dout, 32'd333); end
    checks++; if (remd !== 32'd1) begin errors++; $display("FAIL ce_remd got %h exp %h", remd, 32'd1); end
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ce_done_hold got %0b exp 1", done); end
    ce = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ce_done_clear got %0b exp 0", done); end
  endtask

  task automatic test_reset_mid;
    int cyc; bit bok; bit seen;
    apply_start(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %0b exp 0", done); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL midreset_dout got %h exp 0", dout); end
    checks++; if (remd !== 32'h0) begin errors++; $display("FAIL midreset_remd got %h exp 0", remd); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_done got activity exp none"); end
    apply_start(32'd6, 32'd4);
    wait_done(0, cyc, bok);
    checks++; if (cyc != FULL) begin errors++; $display("FAIL midreset_restart_latency got %0d exp %0d", cyc, FULL); end
    checks++; if (dout !== 32'd1) begin errors++; $display("FAIL midreset_restart_dout got %h exp %h", dout, 32'd1); end
    checks++; if (remd !== 32'd2) begin errors++; $display("FAIL midreset_restart_remd got %h exp %h", remd, 32'd2); end
  endtask

  task automatic test_early_exit;
    logic [31:0] a_v [3] = '{32'd3, 32'd7, 32'd1000};
    logic [31:0] b_v [3] = '{32'd1000, 32'd0, 32'd3};
    logic [31:0] q_v [3] = '{32'd0, 32'hFFFFFFFF, 32'd333};
    logic [31:0] r_v [3] = '{32'd3, 32'd7, 32'd1};
    int lat_v [3] = '{SHORT, SHORT, FULL};
    int cyc; bit bok;
    for (int i = 0; i < 3; i++) begin
      apply_start(a_v[i], b_v[i]);
      wait_done(0, cyc, bok);
      checks++; if (cyc != lat_v[i]) begin errors++; $display("FAIL early_latency[%0d] got %0d exp %0d", i, cyc, lat_v[i]); end
      checks++; if (dout !== q_v[i]) begin errors++; $display("FAIL early_dout[%0d] got %h exp %h", i, dout, q_v[i]); end
      checks++; if (remd !== r_v[i]) begin errors++; $display("FAIL early_remd[%0d] got %h exp %h", i, remd, r_v[i]); end
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_basic;
    test_back_to_back;
    test_corner;
    test_start_while_busy;
    test_ce_stall;
    test_reset_mid;
    test_early_exit;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
